bayer_demosaic_fr: RTL

- Full-resolution Bayer-to-RGB converter for the camera path, placed between the sensor capture/counter stage and the frame-buffer writer.
- Replaces the fixed 12-bit, quarter-rate 2x2 converter with a version that is parametrised in data width, line length and CFA phase.
- Owns its line buffer and its own x/y counters.
- Emits one RGB pixel per accepted input pixel once a full 2x2 window exists.

---
 rtl/bayer_demosaic_fr.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/bayer_demosaic_fr.sv
// Full-resolution Bayer-to-RGB converter: one RGB pixel per accepted raw pixel once a 2x2 window exists.
// Optional white-balance gain stage is enabled by defining DEMOSAIC_WB_GAIN_EN (adds one cycle of latency).
module bayer_demosaic_fr #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 1280,
    parameter int CFA    = 0,
    parameter int XY_W   = 11
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic              iEOL,
`ifdef DEMOSAIC_WB_GAIN_EN
    input  logic [7:0]        iGAIN_R,
    input  logic [7:0]        iGAIN_G,
    input  logic [7:0]        iGAIN_B,
`endif
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL,
    output logic [XY_W-1:0]   oX,
    output logic [XY_W-1:0]   oY,
    output logic              oOVF
);

    localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int CW = XY_W + 1;
    localparam logic [CW-1:0] LINE_LIM = CW'(LINE_W);
    // Parity of the red site within the 2x2 CFA tile.
    localparam logic R_COL = 1'(CFA % 2);
    localparam logic R_ROW = 1'(CFA / 2);

    typedef enum logic [0:0] {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     x_cnt, x_pix;
    logic [XY_W-1:0]   y_cnt, y_pix;
    logic              accept, in_range;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] mem [LINE_W];
    logic [DATA_W-1:0] top_prev, top_cur, bot_prev, bot_cur;
    logic              v1, col_sel, row_sel;
    logic [XY_W-1:0]   x1, y1;
    logic [DATA_W-1:0] red, blue, green;
    logic [DATA_W:0]   g_sum;

    function automatic logic [DATA_W-1:0] pick(input logic prev_col, input logic top_row,
                                                input logic [DATA_W-1:0] tp, input logic [DATA_W-1:0] tc,
                                                input logic [DATA_W-1:0] bp, input logic [DATA_W-1:0] bc);
        case ({top_row, prev_col})
            2'b11:   return tp;
            2'b10:   return tc;
            2'b01:   return bp;
            default: return bc;
        endcase
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= WAIT_SOF;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SOF: if (iDVAL && iSOF) state_nxt = ACTIVE; else state_nxt = WAIT_SOF;
            ACTIVE:   state_nxt = ACTIVE;
            default:  state_nxt = WAIT_SOF;
        endcase
    end

    // A qualified SOF forces the pixel to (0,0) in any state, which is what resynchronises a frame.
    always_comb begin
        accept = 1'b0;
        x_pix  = x_cnt;
        y_pix  = y_cnt;
        if (iDVAL && iSOF) begin
            accept = 1'b1;
            x_pix  = '0;
            y_pix  = '0;
        end else if (iDVAL && (state == ACTIVE)) begin
            accept = 1'b1;
        end else begin
            accept = 1'b0;
        end
    end

    assign in_range = accept && (x_pix < LINE_LIM);
    assign addr     = x_pix[AW-1:0];

    // x saturates at LINE_W so an over-long line can never wrap back into the buffer.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accept) begin
            if (iEOL && !iSOF) begin
                x_cnt <= '0;
                y_cnt <= y_pix + 1'b1;
            end else if (x_pix < LINE_LIM) begin
                x_cnt <= x_pix + 1'b1;
                y_cnt <= y_pix;
            end else begin
                x_cnt <= x_pix;
                y_cnt <= y_pix;
            end
        end else begin
            x_cnt <= x_cnt;
            y_cnt <= y_cnt;
        end
    end

    always_ff @(posedge iCLK) begin
        if (in_range) mem[addr] <= iDATA;
    end

    // Window shift: mem[x] still holds the previous line's sample when it is read here.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            top_prev <= '0;
            top_cur  <= '0;
            bot_prev <= '0;
            bot_cur  <= '0;
        end else if (in_range) begin
            top_prev <= top_cur;
            top_cur  <= mem[addr];
            bot_prev <= bot_cur;
            bot_cur  <= iDATA;
        end else begin
            top_prev <= top_prev;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v1      <= 1'b0;
            x1      <= '0;
            y1      <= '0;
            col_sel <= 1'b0;
            row_sel <= 1'b0;
        end else begin
            v1 <= in_range && (x_pix != '0) && (y_pix != '0);
            if (in_range) begin
                x1      <= x_pix[XY_W-1:0];
                y1      <= y_pix;
                col_sel <= x_pix[0] ^ R_COL;
                row_sel <= y_pix[0] ^ R_ROW;
            end else begin
                x1 <= x1;
            end
        end
    end

    always_comb begin
        red   = pick(col_sel, row_sel, top_prev, top_cur, bot_prev, bot_cur);
        blue  = pick(!col_sel, !row_sel, top_prev, top_cur, bot_prev, bot_cur);
        g_sum = {1'b0, pick(col_sel, !row_sel, top_prev, top_cur, bot_prev, bot_cur)}
              + {1'b0, pick(!col_sel, row_sel, top_prev, top_cur, bot_prev, bot_cur)};
        green = g_sum[DATA_W:1];
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)                          oOVF <= 1'b0;
        else if (accept && !(x_pix < LINE_LIM)) oOVF <= 1'b1;
        else                               oOVF <= oOVF;
    end

`ifdef DEMOSAIC_WB_GAIN_EN
    logic              v2;
    logic [DATA_W-1:0] red2, grn2, blu2;
    logic [XY_W-1:0]   x2, y2;

    // Q4.4 gain: multiply, drop four fraction bits, clamp to full scale.
    function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] c, input logic [7:0] g);
        logic [DATA_W+7:0] prod;
        prod = {8'd0, c} * {{DATA_W{1'b0}}, g};
        if (prod[DATA_W+7:DATA_W+4] != 4'd0) return {DATA_W{1'b1}};
        else                                 return prod[DATA_W+3:4];
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v2 <= 1'b0; red2 <= '0; grn2 <= '0; blu2 <= '0; x2 <= '0; y2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                red2 <= red; grn2 <= green; blu2 <= blue; x2 <= x1; y2 <= y1;
            end else begin
                red2 <= red2;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDVAL <= 1'b0; oRed <= '0; oGreen <= '0; oBlue <= '0; oX <= '0; oY <= '0;
        end else begin
            oDVAL <= v2;
            if (v2) begin
                oRed   <= apply_gain(red2, iGAIN_R);
                oGreen <= apply_gain(grn2, iGAIN_G);
                oBlue  <= apply_gain(blu2, iGAIN_B);
                oX     <= x2;
                oY     <= y2;
            end else begin
                oRed <= oRed;
            end
        end
    end
`else
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDVAL <= 1'b0; oRed <= '0; oGreen <= '0; oBlue <= '0; oX <= '0; oY <= '0;
        end else begin
            oDVAL <= v1;
            if (v1) begin
                oRed   <= red;
                oGreen <= green;
                oBlue  <= blue;
                oX     <= x1;
                oY     <= y1;
            end else begin
                oRed <= oRed;
            end
        end
    end
`endif

endmodule
